// File: rtl/multicyc_ctrl_pkg.sv
// rtl/multicyc_ctrl_pkg.sv - shared types and constants for the EX-stage multi-cycle unit
// Contents: oper_t op encoding, multicyc_state_t FSM states, request/response structs,
//           MUL_LAT_DEF default multiplier depth, op classification helpers.
package cpu_defs;

    localparam int MUL_LAT_DEF = 2;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MADD  = 4'd3,
        OP_MADDU = 4'd4,
        OP_MSUB  = 4'd5,
        OP_MSUBU = 4'd6,
        OP_DIV   = 4'd7,
        OP_DIVU  = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } oper_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_ACC,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } multicyc_state_t;

    typedef struct packed {
        logic        valid;
        oper_t       op;
        logic [31:0] reg0;
        logic [31:0] reg1;
        logic [63:0] hilo;
    } multicyc_req_t;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic        hilo_we;
        logic [63:0] hilo;
    } multicyc_resp_t;

    function automatic logic op_signed(oper_t op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

    function automatic logic op_supported(oper_t op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
                          OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
    endfunction

endpackage

// File: rtl/multicyc_ctrl_if.sv
// rtl/multicyc_ctrl_if.sv - request/response bundle between inst_exec and multicyc_ctrl
// master: drives req_valid/req_op/req_reg0/req_reg1/hilo_i/flush, observes busy/ready/hilo_we/hilo_o
// slave : the multi-cycle controller side
interface multicyc_ctrl_if;
    import cpu_defs::*;

    logic        req_valid;
    oper_t       req_op;
    logic [31:0] req_reg0;
    logic [31:0] req_reg1;
    logic [63:0] hilo_i;
    logic        flush;
    logic        busy;
    logic        ready;
    logic        hilo_we;
    logic [63:0] hilo_o;

    modport master (
        output req_valid, req_op, req_reg0, req_reg1, hilo_i, flush,
        input  busy, ready, hilo_we, hilo_o
    );

    modport slave (
        input  req_valid, req_op, req_reg0, req_reg1, hilo_i, flush,
        output busy, ready, hilo_we, hilo_o
    );

endinterface

// File: rtl/multicyc_ctrl_div_iter.sv
// rtl/multicyc_ctrl_div_iter.sv - restoring radix-2 divider on unsigned magnitudes
// Ports: clk, rst_n (sync, active-low), start (load operands), dividend, divisor,
//        done (high during the final iteration cycle; results valid the cycle after),
//        quotient, remainder.
module div_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q, quo_q, dvs_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    logic [W:0]    shifted;
    logic          ge;
    logic [W-1:0]  sub;

    // Partial remainder is always below the divisor, so the trial difference fits W bits.
    // With a zero divisor every trial succeeds: quotient all ones, remainder = dividend.
    assign shifted = {rem_q, quo_q[W-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign sub     = W'(shifted - {1'b0, dvs_q});
    assign done    = run_q && (cnt_q == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= ge ? sub : shifted[W-1:0];
            quo_q <= {quo_q[W-2:0], ge};
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/multicyc_ctrl.sv
// rtl/multicyc_ctrl.sv - EX-stage multi-cycle HI/LO sequencer (mult/madd/msub/div/mthi/mtlo)
// Ports: clk, rst_n (sync, active-low), bus (multicyc_ctrl_if.slave):
//        req_valid/req_op/req_reg0/req_reg1/hilo_i/flush in; busy/ready/hilo_we/hilo_o out.
module multicyc_ctrl
    import cpu_defs::*;
#(
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int DIV_BITS = 32
) (
    input logic             clk,
    input logic             rst_n,
    multicyc_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    multicyc_req_t   req;
    multicyc_resp_t  resp;
    multicyc_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    oper_t           op_q;
    logic            qneg_q, rneg_q;
    logic [63:0]     result_q, result_d;
    logic [63:0]     mul_pipe_q [MUL_LAT];

    logic            accept, sgn, mul_last;
    logic [63:0]     mul_a, mul_b;
    logic [31:0]     mag0, mag1;
    logic            div_start, div_done;
    logic [31:0]     div_quo, div_rem, quo_fix, rem_fix;

    assign req = '{valid: bus.req_valid, op: bus.req_op, reg0: bus.req_reg0,
                   reg1: bus.req_reg1, hilo: bus.hilo_i};

    assign sgn       = op_signed(req.op);
    assign accept    = (state_q == ST_IDLE) && req.valid && !bus.flush && op_supported(req.op);
    assign mul_last  = cnt_q == CNT_W'(MUL_LAT - 1);

    // Sign-extended 64x64 product truncated to 64 bits equals the 32x32 signed product.
    assign mul_a = {{32{sgn & req.reg0[31]}}, req.reg0};
    assign mul_b = {{32{sgn & req.reg1[31]}}, req.reg1};

    assign mag0      = (sgn && req.reg0[31]) ? -req.reg0 : req.reg0;
    assign mag1      = (sgn && req.reg1[31]) ? -req.reg1 : req.reg1;
    assign div_start = accept && (req.op inside {OP_DIV, OP_DIVU});

    assign quo_fix = qneg_q ? -div_quo : div_quo;
    assign rem_fix = rneg_q ? -div_rem : div_rem;

    div_iter #(.W(DIV_BITS)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (mag0),
        .divisor   (mag1),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Product is captured at accept and walks the chain; synthesis may retime the '*' into it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < MUL_LAT; k++) mul_pipe_q[k] <= '0;
        end else begin
            if (accept) mul_pipe_q[0] <= mul_a * mul_b;
            for (int k = 1; k < MUL_LAT; k++) mul_pipe_q[k] <= mul_pipe_q[k-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (req.op)
                        OP_MTHI:         begin result_d = {req.reg0, req.hilo[31:0]};  state_d = ST_DONE; end
                        OP_MTLO:         begin result_d = {req.hilo[63:32], req.reg0}; state_d = ST_DONE; end
                        OP_DIV, OP_DIVU: state_d = ST_DIV;
                        default:         state_d = ST_MUL;
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    cnt_d    = '0;
                    result_d = mul_pipe_q[MUL_LAT-1];
                    state_d  = (op_q inside {OP_MULT, OP_MULTU}) ? ST_DONE : ST_ACC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACC: begin
                result_d = (op_q inside {OP_MSUB, OP_MSUBU}) ? req.hilo - result_q
                                                             : req.hilo + result_q;
                state_d  = ST_DONE;
            end
            ST_DIV:  if (div_done) state_d = ST_FIX;
            ST_FIX: begin
                result_d = {rem_fix, quo_fix};
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            op_q     <= OP_NONE;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            if (accept) begin
                op_q   <= req.op;
                qneg_q <= sgn & (req.reg0[31] ^ req.reg1[31]);
                rneg_q <= sgn & req.reg0[31];
            end
        end
    end

    always_comb begin
        resp         = '0;
        resp.busy    = state_q != ST_IDLE;
        resp.ready   = (state_q == ST_DONE) && !bus.flush;
        resp.hilo_we = resp.ready;
        resp.hilo    = resp.ready ? result_q : 64'd0;
    end

    assign bus.busy    = resp.busy;
    assign bus.ready   = resp.ready;
    assign bus.hilo_we = resp.hilo_we;
    assign bus.hilo_o  = resp.hilo;

endmodule
